// File: rtl/branch_predict_unit.sv
// rtl/branch_predict_unit.sv - BTB plus saturating-counter direction predictor
// Combinational IF-stage lookup, MM-stage training, optional gshare indexing and mispredict stats.
module branch_predict_unit #(
   parameter int ENTRIES = 4,
   parameter int CTR_W   = 2,
   parameter int MODE    = 0,
   parameter int CNT_W   = 16,
   localparam int IDX_W  = $clog2(ENTRIES),
   localparam int TAG_W  = 30 - IDX_W
) (
   input  logic             CLK,
   input  logic             nRST,
   input  logic [31:0]      lookup_pc,
   output logic             pred_hit,
   output logic             pred_taken,
   output logic [31:0]      pred_target,
   input  logic             upd_en,
   input  logic [31:0]      upd_pc,
   input  logic             upd_taken,
   input  logic [31:0]      upd_target,
   input  logic             upd_mispredict,
   output logic [IDX_W-1:0] ghr,
   output logic [CNT_W-1:0] mispredict_cnt
);

   if ((ENTRIES < 2) || (ENTRIES > 256) || ((ENTRIES & (ENTRIES - 1)) != 0)) begin : g_bad_entries
      $error("branch_predict_unit: ENTRIES must be a power of 2 in 2..256");
   end
   if ((CTR_W < 1) || (CTR_W > 4)) begin : g_bad_ctr_w
      $error("branch_predict_unit: CTR_W must be in 1..4");
   end

   localparam logic [CTR_W-1:0] CTR_MAX = '1;
   localparam logic [CTR_W-1:0] CTR_WT  = CTR_W'(1) << (CTR_W - 1);
   localparam logic [CTR_W-1:0] CTR_WNT = CTR_WT - CTR_W'(1);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic             r_valid  [ENTRIES];
   logic [TAG_W-1:0] r_tag    [ENTRIES];
   logic [31:0]      r_target [ENTRIES];
   logic [CTR_W-1:0] r_ctr    [ENTRIES];
   logic [IDX_W-1:0] r_ghr;
   logic [CNT_W-1:0] r_cnt;

   logic [IDX_W-1:0] w_hash;
   logic [IDX_W-1:0] w_lk_idx;
   logic [IDX_W-1:0] w_up_idx;
   logic [TAG_W-1:0] w_lk_tag;
   logic [TAG_W-1:0] w_up_tag;
   logic             w_up_hit;
   logic [CTR_W-1:0] w_up_ctr;
   logic [IDX_W-1:0] w_ghr_next;

   // Bimodal mode never shifts history, so hashing with r_ghr is a no-op there.
   assign w_hash     = (MODE == 1) ? r_ghr : '0;
   assign w_lk_idx   = lookup_pc[IDX_W+1:2] ^ w_hash;
   assign w_up_idx   = upd_pc[IDX_W+1:2] ^ w_hash;
   assign w_lk_tag   = lookup_pc[31:IDX_W+2];
   assign w_up_tag   = upd_pc[31:IDX_W+2];
   assign w_up_hit   = r_valid[w_up_idx] && (r_tag[w_up_idx] == w_up_tag);
   assign w_up_ctr   = r_ctr[w_up_idx];
   assign w_ghr_next = (MODE == 1) ? IDX_W'({r_ghr, upd_taken}) : '0;

   assign pred_hit       = r_valid[w_lk_idx] && (r_tag[w_lk_idx] == w_lk_tag);
   assign pred_taken     = pred_hit && r_ctr[w_lk_idx][CTR_W-1];
   assign pred_target    = r_target[w_lk_idx];
   assign ghr            = r_ghr;
   assign mispredict_cnt = r_cnt;

   always_ff @(posedge CLK) begin
      if (!nRST) begin
         for (int i = 0; i < ENTRIES; i++) begin
            r_valid[i]  <= 1'b0;
            r_tag[i]    <= '0;
            r_target[i] <= '0;
            r_ctr[i]    <= CTR_WNT;
         end
         r_ghr <= '0;
         r_cnt <= '0;
      end else if (upd_en) begin
         if (w_up_hit) begin
            if (upd_taken) begin
               r_ctr[w_up_idx]    <= (w_up_ctr == CTR_MAX) ? w_up_ctr : w_up_ctr + 1'b1;
               r_target[w_up_idx] <= upd_target;
            end else begin
               r_ctr[w_up_idx]    <= (w_up_ctr == '0) ? w_up_ctr : w_up_ctr - 1'b1;
            end
         end else if (upd_taken) begin
            r_valid[w_up_idx]  <= 1'b1;
            r_tag[w_up_idx]    <= w_up_tag;
            r_target[w_up_idx] <= upd_target;
            r_ctr[w_up_idx]    <= CTR_WT;
         end
         r_ghr <= w_ghr_next;
         if (upd_mispredict && (r_cnt != CNT_MAX)) begin
            r_cnt <= r_cnt + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_branch_predict_unit.sv
// tb/tb_branch_predict_unit.sv - directed bench for branch_predict_unit
// Four instances share stimulus: bimodal 4x2b, gshare 8x2b, 2-bit stat counter, 1-bit counter.
module tb_branch_predict_unit;

   logic        CLK = 1'b0;
   logic        nRST = 1'b0;
   logic [31:0] lookup_pc = 32'h0;
   logic        upd_en = 1'b0;
   logic [31:0] upd_pc = 32'h0;
   logic        upd_taken = 1'b0;
   logic [31:0] upd_target = 32'h0;
   logic        upd_mispredict = 1'b0;

   logic        d0_hit, d0_taken, d1_hit, d1_taken, d2_hit, d2_taken, d3_hit, d3_taken;
   logic [31:0] d0_tgt, d1_tgt, d2_tgt, d3_tgt;
   logic [1:0]  d0_ghr, d2_ghr, d3_ghr;
   logic [2:0]  d1_ghr;
   logic [15:0] d0_cnt, d1_cnt, d3_cnt;
   logic [1:0]  d2_cnt;

   int n_cmp = 0;
   int n_err = 0;

   always #5 CLK = ~CLK;

   branch_predict_unit #(.ENTRIES(4), .CTR_W(2), .MODE(0), .CNT_W(16)) dut0 (
      .CLK(CLK), .nRST(nRST), .lookup_pc(lookup_pc), .pred_hit(d0_hit), .pred_taken(d0_taken),
      .pred_target(d0_tgt), .upd_en(upd_en), .upd_pc(upd_pc), .upd_taken(upd_taken),
      .upd_target(upd_target), .upd_mispredict(upd_mispredict), .ghr(d0_ghr), .mispredict_cnt(d0_cnt));

   branch_predict_unit #(.ENTRIES(8), .CTR_W(2), .MODE(1), .CNT_W(16)) dut1 (
      .CLK(CLK), .nRST(nRST), .lookup_pc(lookup_pc), .pred_hit(d1_hit), .pred_taken(d1_taken),
      .pred_target(d1_tgt), .upd_en(upd_en), .upd_pc(upd_pc), .upd_taken(upd_taken),
      .upd_target(upd_target), .upd_mispredict(upd_mispredict), .ghr(d1_ghr), .mispredict_cnt(d1_cnt));

   branch_predict_unit #(.ENTRIES(4), .CTR_W(2), .MODE(0), .CNT_W(2)) dut2 (
      .CLK(CLK), .nRST(nRST), .lookup_pc(lookup_pc), .pred_hit(d2_hit), .pred_taken(d2_taken),
      .pred_target(d2_tgt), .upd_en(upd_en), .upd_pc(upd_pc), .upd_taken(upd_taken),
      .upd_target(upd_target), .upd_mispredict(upd_mispredict), .ghr(d2_ghr), .mispredict_cnt(d2_cnt));

   branch_predict_unit #(.ENTRIES(4), .CTR_W(1), .MODE(0), .CNT_W(16)) dut3 (
      .CLK(CLK), .nRST(nRST), .lookup_pc(lookup_pc), .pred_hit(d3_hit), .pred_taken(d3_taken),
      .pred_target(d3_tgt), .upd_en(upd_en), .upd_pc(upd_pc), .upd_taken(upd_taken),
      .upd_target(upd_target), .upd_mispredict(upd_mispredict), .ghr(d3_ghr), .mispredict_cnt(d3_cnt));

   task automatic do_upd(input logic [31:0] pc, input logic tk, input logic [31:0] tgt, input logic mp);
      upd_en = 1'b1; upd_pc = pc; upd_taken = tk; upd_target = tgt; upd_mispredict = mp;
      @(posedge CLK); #1;
      upd_en = 1'b0; upd_mispredict = 1'b0;
   endtask

   task automatic look(input logic [31:0] pc);
      lookup_pc = pc; #1;
   endtask

   // Reset with a concurrent taken+mispredict update: reset must win.
   task automatic test_reset;
      nRST = 1'b0; upd_en = 1'b1; upd_pc = 32'h40; upd_taken = 1'b1; upd_target = 32'h80; upd_mispredict = 1'b1;
      @(posedge CLK); #1;
      nRST = 1'b1; upd_en = 1'b0; upd_mispredict = 1'b0;
      look(32'h40);
      n_cmp++; if (d0_hit !== 1'b0) begin n_err++; $display("FAIL reset_hit got %0b want 0", d0_hit); end
      n_cmp++; if (d0_taken !== 1'b0) begin n_err++; $display("FAIL reset_taken got %0b want 0", d0_taken); end
      n_cmp++; if (d0_tgt !== 32'h0) begin n_err++; $display("FAIL reset_target got %h want 0", d0_tgt); end
      n_cmp++; if (d0_cnt !== 16'd0) begin n_err++; $display("FAIL reset_cnt got %0d want 0", d0_cnt); end
      n_cmp++; if (d1_ghr !== 3'b000) begin n_err++; $display("FAIL reset_ghr got %b want 000", d1_ghr); end
   endtask

   task automatic test_alloc;
      do_upd(32'h40, 1'b1, 32'h80, 1'b0);
      look(32'h40);
      n_cmp++; if (d0_hit !== 1'b1) begin n_err++; $display("FAIL alloc_hit got %0b want 1", d0_hit); end
      n_cmp++; if (d0_taken !== 1'b1) begin n_err++; $display("FAIL alloc_taken got %0b want 1", d0_taken); end
      n_cmp++; if (d0_tgt !== 32'h80) begin n_err++; $display("FAIL alloc_target got %h want 80", d0_tgt); end
      n_cmp++; if (d3_taken !== 1'b1) begin n_err++; $display("FAIL c1_alloc_taken got %0b want 1", d3_taken); end
      n_cmp++; if (d0_ghr !== 2'b00) begin n_err++; $display("FAIL bimodal_ghr got %b want 00", d0_ghr); end
   endtask

   // ctr 2 -> 1 -> 0 -> 0, then one taken: 1 (weakly NT) proves no wrap to 3.
   task automatic test_saturate;
      do_upd(32'h40, 1'b0, 32'hDEAD, 1'b0);
      look(32'h40);
      n_cmp++; if (d0_taken !== 1'b0) begin n_err++; $display("FAIL dec1_taken got %0b want 0", d0_taken); end
      n_cmp++; if (d0_hit !== 1'b1) begin n_err++; $display("FAIL dec1_hit got %0b want 1", d0_hit); end
      n_cmp++; if (d0_tgt !== 32'h80) begin n_err++; $display("FAIL nt_keeps_target got %h want 80", d0_tgt); end
      n_cmp++; if (d3_taken !== 1'b0) begin n_err++; $display("FAIL c1_nt_taken got %0b want 0", d3_taken); end
      do_upd(32'h40, 1'b0, 32'h0, 1'b0);
      do_upd(32'h40, 1'b0, 32'h0, 1'b0);
      look(32'h40);
      n_cmp++; if ({d0_hit, d0_taken} !== 2'b10) begin n_err++; $display("FAIL dec3_hit_taken got %b want 10", {d0_hit, d0_taken}); end
      do_upd(32'h40, 1'b1, 32'h84, 1'b0);
      look(32'h40);
      n_cmp++; if (d0_taken !== 1'b0) begin n_err++; $display("FAIL floor_then_inc_taken got %0b want 0", d0_taken); end
      n_cmp++; if (d0_tgt !== 32'h84) begin n_err++; $display("FAIL hit_target_update got %h want 84", d0_tgt); end
      n_cmp++; if (d3_taken !== 1'b1) begin n_err++; $display("FAIL c1_retaken got %0b want 1", d3_taken); end
   endtask

   // 0x50 shares index 0 with 0x40 but has a different tag.
   task automatic test_alias;
      upd_en = 1'b1; upd_pc = 32'h50; upd_taken = 1'b1; upd_target = 32'hA0; upd_mispredict = 1'b0;
      look(32'h50);
      n_cmp++; if (d0_hit !== 1'b0) begin n_err++; $display("FAIL same_cycle_hit got %0b want 0", d0_hit); end
      look(32'h40);
      n_cmp++; if (d0_hit !== 1'b1) begin n_err++; $display("FAIL same_cycle_old_hit got %0b want 1", d0_hit); end
      @(posedge CLK); #1;
      upd_en = 1'b0;
      look(32'h50);
      n_cmp++; if ({d0_hit, d0_taken} !== 2'b11) begin n_err++; $display("FAIL alias_new got %b want 11", {d0_hit, d0_taken}); end
      n_cmp++; if (d0_tgt !== 32'hA0) begin n_err++; $display("FAIL alias_target got %h want a0", d0_tgt); end
      look(32'h40);
      n_cmp++; if (d0_hit !== 1'b0) begin n_err++; $display("FAIL alias_evicted got %0b want 0", d0_hit); end
   endtask

   task automatic test_gshare;
      nRST = 1'b0; @(posedge CLK); #1; nRST = 1'b1;
      do_upd(32'h100, 1'b1, 32'h111, 1'b0);
      do_upd(32'h200, 1'b0, 32'h222, 1'b0);
      do_upd(32'h300, 1'b1, 32'h333, 1'b0);
      n_cmp++; if (d1_ghr !== 3'b101) begin n_err++; $display("FAIL ghr_101 got %b want 101", d1_ghr); end
      // Writes index (4 ^ 5) = 1; history then becomes 011.
      do_upd(32'h10, 1'b1, 32'h1234, 1'b0);
      n_cmp++; if (d1_ghr !== 3'b011) begin n_err++; $display("FAIL ghr_011 got %b want 011", d1_ghr); end
      look(32'h10);
      n_cmp++; if (d1_hit !== 1'b0) begin n_err++; $display("FAIL gshare_rehash_miss got %0b want 0", d1_hit); end
      // 0x08 has tag 0 and hashes to (2 ^ 3) = 1 under ghr 011.
      look(32'h08);
      n_cmp++; if ({d1_hit, d1_taken} !== 2'b11) begin n_err++; $display("FAIL gshare_idx1 got %b want 11", {d1_hit, d1_taken}); end
      n_cmp++; if (d1_tgt !== 32'h1234) begin n_err++; $display("FAIL gshare_target got %h want 1234", d1_tgt); end
      n_cmp++; if (d0_ghr !== 2'b00) begin n_err++; $display("FAIL bimodal_ghr_stays got %b want 00", d0_ghr); end
   endtask

   task automatic test_mispredict_cnt;
      logic [1:0] exp2;
      nRST = 1'b0; @(posedge CLK); #1; nRST = 1'b1;
      for (int i = 1; i <= 5; i++) begin
         do_upd(32'h20, 1'b0, 32'h0, 1'b1);
         exp2 = (i >= 3) ? 2'd3 : 2'(i);
         n_cmp++; if (d2_cnt !== exp2) begin n_err++; $display("FAIL cnt_sat_%0d got %0d want %0d", i, d2_cnt, exp2); end
      end
      n_cmp++; if (d0_cnt !== 16'd5) begin n_err++; $display("FAIL cnt_wide got %0d want 5", d0_cnt); end
      // upd_en low: every other upd_* input is ignored.
      upd_en = 1'b0; upd_pc = 32'h40; upd_taken = 1'b1; upd_target = 32'h99; upd_mispredict = 1'b1;
      @(posedge CLK); #1;
      upd_mispredict = 1'b0;
      look(32'h40);
      n_cmp++; if (d0_hit !== 1'b0) begin n_err++; $display("FAIL hold_no_alloc got %0b want 0", d0_hit); end
      n_cmp++; if (d0_cnt !== 16'd5) begin n_err++; $display("FAIL hold_cnt got %0d want 5", d0_cnt); end
      nRST = 1'b0; upd_en = 1'b1; upd_pc = 32'h40; upd_taken = 1'b1; upd_mispredict = 1'b1;
      @(posedge CLK); #1;
      nRST = 1'b1; upd_en = 1'b0; upd_mispredict = 1'b0;
      look(32'h40);
      n_cmp++; if (d2_cnt !== 2'd0) begin n_err++; $display("FAIL rst_over_upd_cnt got %0d want 0", d2_cnt); end
      n_cmp++; if (d0_hit !== 1'b0) begin n_err++; $display("FAIL rst_over_upd_hit got %0b want 0", d0_hit); end
   endtask

   initial begin
      repeat (2) @(posedge CLK);
      #1;
      test_reset;
      test_alloc;
      test_saturate;
      test_alias;
      test_gshare;
      test_mispredict_cnt;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
